// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - fetch stage control, memory and IF/ID bundle
interface instruction_fetch_unit_if;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic        Halt;
    logic [31:0] InstrAddress;
    logic [31:0] InstrData;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic [31:0] FetchCount;
    logic        Halted;

    // Fetch unit side
    modport master (
        input  Stall, Redirect, RedirectTarget, Halt, InstrData,
        output InstrAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount, Halted
    );

    // Pipeline / memory side
    modport slave (
        output Stall, Redirect, RedirectTarget, Halt, InstrData,
        input  InstrAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount, Halted
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, IF/ID register and start/run/halt control
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic                          Clk,
    input  logic                          Reset,
    instruction_fetch_unit_if.master      bus
);
    typedef enum logic [1:0] {
        START  = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ifid_instruction;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic [31:0] fetch_count;
    logic        halted;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;

    // Sequential PC increment wraps modulo 2^32; redirect targets are forced word aligned
    assign pc_plus4    = pc + 32'd4;
    assign redirect_pc = bus.RedirectTarget & ~32'h00000003;

    // Memory address comes straight from the PC, no extra register in between
    assign bus.InstrAddress     = pc;
    assign bus.IFID_Instruction = ifid_instruction;
    assign bus.IFID_PCPlus4     = ifid_pc_plus4;
    assign bus.IFID_Valid       = ifid_valid;
    assign bus.FetchCount       = fetch_count;
    assign bus.Halted           = halted;

    // Fetch state machine: Reset > Halt > Redirect > Stall > normal capture
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state            <= START;
            pc               <= RESET_PC;
            ifid_instruction <= NOP_WORD;
            ifid_pc_plus4    <= 32'd0;
            ifid_valid       <= 1'b0;
            fetch_count      <= 32'd0;
            halted           <= 1'b0;
        end else begin
            case (state)
                START: begin
                    state <= RUN;
                end
                RUN: begin
                    if (bus.Halt) begin
                        state            <= HALTED;
                        halted           <= 1'b1;
                        ifid_instruction <= NOP_WORD;
                        ifid_valid       <= 1'b0;
                    end else if (bus.Redirect) begin
                        pc               <= redirect_pc;
                        ifid_instruction <= NOP_WORD;
                        ifid_valid       <= 1'b0;
                    end else if (!bus.Stall) begin
                        ifid_instruction <= bus.InstrData;
                        ifid_pc_plus4    <= pc_plus4;
                        ifid_valid       <= 1'b1;
                        pc               <= pc_plus4;
                        fetch_count      <= fetch_count + 32'd1;
                    end
                end
                HALTED: begin
                    halted     <= 1'b1;
                    ifid_valid <= 1'b0;
                end
                default: begin
                    state <= START;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed and randomized bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h00000000;
    localparam logic [31:0] NOP_WORD = 32'h00000000;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: distinct word per address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, ~a[17:2]};
    endfunction

    always_comb bus.InstrData = mem_word(bus.InstrAddress);

    // Reference model: architectural effect of each clock edge
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid, m_halted, m_start;

    always @(posedge clk) begin
        if (reset) begin
            m_pc <= RESET_PC; m_instr <= NOP_WORD; m_pc4 <= 32'd0; m_valid <= 1'b0;
            m_cnt <= 32'd0; m_halted <= 1'b0; m_start <= 1'b1;
        end else if (m_start) begin
            m_start <= 1'b0;
        end else if (m_halted) begin
            m_valid <= 1'b0;
        end else if (bus.Halt) begin
            m_halted <= 1'b1; m_instr <= NOP_WORD; m_valid <= 1'b0;
        end else if (bus.Redirect) begin
            m_pc <= (bus.RedirectTarget / 4) * 4; m_instr <= NOP_WORD; m_valid <= 1'b0;
        end else if (!bus.Stall) begin
            m_instr <= mem_word(m_pc); m_pc4 <= m_pc + 4; m_valid <= 1'b1;
            m_pc <= m_pc + 4; m_cnt <= m_cnt + 1;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.Stall = 1'b0; bus.Redirect = 1'b0; bus.Halt = 1'b0; bus.RedirectTarget = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1; tick();
        reset = 1'b0; tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.Stall = 1'b1; bus.Redirect = 1'b1; bus.Halt = 1'b1;
        bus.RedirectTarget = 32'h1234_5678;
        tick(); tick();
        checks++; if (bus.InstrAddress !== RESET_PC) begin errors++; $display("FAIL reset_pc got=%h exp=%h", bus.InstrAddress, RESET_PC); end
        checks++; if (bus.IFID_Instruction !== NOP_WORD) begin errors++; $display("FAIL reset_instr got=%h exp=%h", bus.IFID_Instruction, NOP_WORD); end
        checks++; if (bus.IFID_PCPlus4 !== 32'd0) begin errors++; $display("FAIL reset_pc4 got=%h exp=0", bus.IFID_PCPlus4); end
        checks++; if ({bus.IFID_Valid, bus.Halted} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {bus.IFID_Valid, bus.Halted}); end
        checks++; if (bus.FetchCount !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.FetchCount); end
        idle_inputs();
    endtask

    task automatic test_startup();
        do_reset();
        checks++; if (bus.InstrAddress !== 32'd0 || bus.IFID_Valid !== 1'b0) begin errors++; $display("FAIL start_cycle addr=%h valid=%b exp addr=0 valid=0", bus.InstrAddress, bus.IFID_Valid); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (bus.IFID_PCPlus4 !== 32'(4 * i) || bus.IFID_Valid !== 1'b1) begin errors++; $display("FAIL startup_pc4 got=%h/%b exp=%h/1", bus.IFID_PCPlus4, bus.IFID_Valid, 4 * i); end
            checks++; if (bus.IFID_Instruction !== mem_word(32'(4 * (i - 1)))) begin errors++; $display("FAIL startup_instr got=%h exp=%h", bus.IFID_Instruction, mem_word(32'(4 * (i - 1)))); end
        end
        checks++; if (bus.FetchCount !== 32'd3) begin errors++; $display("FAIL startup_count got=%0d exp=3", bus.FetchCount); end
    endtask

    task automatic test_stall();
        tick();
        bus.Stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus.InstrAddress !== 32'd16 || bus.IFID_PCPlus4 !== 32'd16 || bus.FetchCount !== 32'd4 || bus.IFID_Valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold addr=%h pc4=%h cnt=%0d valid=%b exp 10/10/4/1", bus.InstrAddress, bus.IFID_PCPlus4, bus.FetchCount, bus.IFID_Valid); end
        end
        bus.Stall = 1'b0;
        tick();
        checks++; if (bus.InstrAddress !== 32'd20 || bus.IFID_PCPlus4 !== 32'd20 || bus.FetchCount !== 32'd5) begin
            errors++; $display("FAIL stall_release addr=%h pc4=%h cnt=%0d exp 14/14/5", bus.InstrAddress, bus.IFID_PCPlus4, bus.FetchCount); end
    endtask

    task automatic test_redirect();
        do_reset(); tick(); tick();
        bus.Redirect = 1'b1; bus.RedirectTarget = 32'h00000043;
        tick(); idle_inputs();
        checks++; if (bus.InstrAddress !== 32'h40 || bus.IFID_Valid !== 1'b0 || bus.IFID_Instruction !== NOP_WORD || bus.FetchCount !== 32'd2) begin
            errors++; $display("FAIL redirect_bubble addr=%h valid=%b instr=%h cnt=%0d exp 40/0/nop/2", bus.InstrAddress, bus.IFID_Valid, bus.IFID_Instruction, bus.FetchCount); end
        tick();
        checks++; if (bus.IFID_PCPlus4 !== 32'h44 || bus.IFID_Valid !== 1'b1 || bus.IFID_Instruction !== mem_word(32'h40)) begin
            errors++; $display("FAIL redirect_next pc4=%h valid=%b instr=%h exp 44/1/%h", bus.IFID_PCPlus4, bus.IFID_Valid, bus.IFID_Instruction, mem_word(32'h40)); end
        bus.Stall = 1'b1; bus.Redirect = 1'b1; bus.RedirectTarget = 32'h100;
        tick(); idle_inputs();
        checks++; if (bus.InstrAddress !== 32'h100 || bus.IFID_Valid !== 1'b0 || bus.FetchCount !== 32'd3) begin
            errors++; $display("FAIL redirect_over_stall addr=%h valid=%b cnt=%0d exp 100/0/3", bus.InstrAddress, bus.IFID_Valid, bus.FetchCount); end
    endtask

    task automatic test_halt();
        bus.Redirect = 1'b1; bus.RedirectTarget = 32'h20;
        tick(); idle_inputs();
        bus.Halt = 1'b1;
        tick();
        checks++; if (bus.Halted !== 1'b1 || bus.InstrAddress !== 32'h20 || bus.IFID_Valid !== 1'b0) begin
            errors++; $display("FAIL halt_enter halted=%b addr=%h valid=%b exp 1/20/0", bus.Halted, bus.InstrAddress, bus.IFID_Valid); end
        for (int i = 0; i < 5; i++) begin
            bus.Halt = 1'($urandom_range(0, 1)); bus.Stall = 1'($urandom_range(0, 1));
            bus.Redirect = 1'($urandom_range(0, 1)); bus.RedirectTarget = $urandom;
            tick();
            checks++; if (bus.Halted !== 1'b1 || bus.InstrAddress !== 32'h20 || bus.IFID_Valid !== 1'b0 || bus.FetchCount !== m_cnt) begin
                errors++; $display("FAIL halt_frozen halted=%b addr=%h valid=%b cnt=%0d exp 1/20/0/%0d", bus.Halted, bus.InstrAddress, bus.IFID_Valid, bus.FetchCount, m_cnt); end
        end
        idle_inputs(); reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (bus.Halted !== 1'b0 || bus.InstrAddress !== RESET_PC || bus.FetchCount !== 32'd0) begin
            errors++; $display("FAIL halt_reset halted=%b addr=%h cnt=%0d exp 0/%h/0", bus.Halted, bus.InstrAddress, bus.FetchCount, RESET_PC); end
    endtask

    task automatic test_halt_priority();
        bus.Halt = 1'b1;
        tick();
        checks++; if (bus.Halted !== 1'b0 || bus.InstrAddress !== 32'd0) begin
            errors++; $display("FAIL halt_in_start halted=%b addr=%h exp 0/0", bus.Halted, bus.InstrAddress); end
        bus.Halt = 1'b0; tick();
        bus.Halt = 1'b1; bus.Redirect = 1'b1; bus.RedirectTarget = 32'h80;
        tick(); idle_inputs();
        checks++; if (bus.Halted !== 1'b1 || bus.InstrAddress !== 32'd4 || bus.FetchCount !== 32'd1) begin
            errors++; $display("FAIL halt_over_redirect halted=%b addr=%h cnt=%0d exp 1/4/1", bus.Halted, bus.InstrAddress, bus.FetchCount); end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.Redirect = 1'b1; bus.RedirectTarget = 32'hFFFFFFFF;
        tick(); idle_inputs();
        checks++; if (bus.InstrAddress !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_target got=%h exp=fffffffc", bus.InstrAddress); end
        tick();
        checks++; if (bus.IFID_PCPlus4 !== 32'd0 || bus.InstrAddress !== 32'd0 || bus.IFID_Instruction !== mem_word(32'hFFFFFFFC)) begin
            errors++; $display("FAIL wrap_pc4 pc4=%h addr=%h instr=%h exp 0/0/%h", bus.IFID_PCPlus4, bus.InstrAddress, bus.IFID_Instruction, mem_word(32'hFFFFFFFC)); end
    endtask

    task automatic test_reset_during_stall();
        tick(); tick();
        bus.Stall = 1'b1; tick();
        reset = 1'b1; tick();
        checks++; if (bus.InstrAddress !== RESET_PC || bus.IFID_Valid !== 1'b0 || bus.IFID_PCPlus4 !== 32'd0 || bus.FetchCount !== 32'd0 || bus.IFID_Instruction !== NOP_WORD) begin
            errors++; $display("FAIL reset_in_stall addr=%h valid=%b pc4=%h cnt=%0d instr=%h exp reset values", bus.InstrAddress, bus.IFID_Valid, bus.IFID_PCPlus4, bus.FetchCount, bus.IFID_Instruction); end
        reset = 1'b0; idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset              = ($urandom_range(0, 99) < 1);
            bus.Stall          = ($urandom_range(0, 99) < 25);
            bus.Redirect       = ($urandom_range(0, 99) < 10);
            bus.Halt           = ($urandom_range(0, 99) < 2);
            bus.RedirectTarget = $urandom;
            tick();
            checks++; if (bus.InstrAddress !== m_pc) begin errors++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", i, bus.InstrAddress, m_pc); end
            checks++; if (bus.IFID_Valid !== m_valid || bus.Halted !== m_halted) begin errors++; $display("FAIL rand_flags cyc=%0d got=%b%b exp=%b%b", i, bus.IFID_Valid, bus.Halted, m_valid, m_halted); end
            checks++; if (bus.IFID_Instruction !== m_instr) begin errors++; $display("FAIL rand_instr cyc=%0d got=%h exp=%h", i, bus.IFID_Instruction, m_instr); end
            checks++; if (bus.IFID_PCPlus4 !== m_pc4) begin errors++; $display("FAIL rand_pc4 cyc=%0d got=%h exp=%h", i, bus.IFID_PCPlus4, m_pc4); end
            checks++; if (bus.FetchCount !== m_cnt) begin errors++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", i, bus.FetchCount, m_cnt); end
        end
        reset = 1'b0; idle_inputs();
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; idle_inputs();
        tick();
        test_reset();
        test_startup();
        test_stall();
        test_redirect();
        test_halt();
        test_halt_priority();
        test_wrap();
        test_reset_during_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage of the single-issue MIPS pipeline. Holds the program counter and drives the byte address into the combinational InstructionMemory. Captures the returned word into the IF/ID pipeline register. Handles stall, branch/jump redirect, halt and a post-reset start-up cycle, and keeps a fetched-instruction counter for debug.

Parameters:
RESET_PC  32'h00000000  PC value loaded on reset (word aligned)
NOP_WORD  32'h00000000  bubble instruction written into IF/ID on redirect or halt

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
Stall  input  1  hazard-unit stall; hold PC and IF/ID
Redirect  input  1  branch taken or jump resolved this cycle
RedirectTarget  input  32  new PC on Redirect; bits [1:0] ignored
Halt  input  1  stop fetching until next Reset
InstrAddress  output  32  byte address to InstructionMemory Address; equals PC combinationally
InstrData  input  32  InstructionMemory Instruction; valid same cycle as InstrAddress
IFID_Instruction  output  32  registered fetched instruction
IFID_PCPlus4  output  32  registered PC+4 of that instruction
IFID_Valid  output  1  IF/ID holds a real instruction, not a bubble
FetchCount  output  32  number of instructions captured since reset
Halted  output  1  high while in HALTED state

Behaviour:
- Interface: one clock (Clk); reset is synchronous and active-high (Reset). Reset is sampled only at the rising edge of Clk.
- On reset: PC=RESET_PC, IFID_Instruction=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0, FetchCount=0, Halted=0, state=START.
- InstrAddress = PC at all times. There is no address register between the PC and memory.
- State machine: START, RUN, HALTED.
  - START: lasts exactly one cycle after Reset deasserts. No capture, PC held, IF/ID stays a bubble. Moves to RUN unconditionally. Halt is ignored in START.
  - RUN: normal fetch, with the per-cycle priority given below.
  - HALTED: PC, FetchCount and IF/ID frozen, IFID_Valid=0, Halted=1. Leaves only on Reset.
- RUN per-cycle priority, highest first:
  1. Reset.
  2. Halt: go to HALTED. IF/ID becomes a bubble (Instruction=NOP_WORD, Valid=0). PC unchanged.
  3. Redirect: PC <= {RedirectTarget[31:2],2'b00}. IF/ID becomes a bubble. FetchCount unchanged. Redirect overrides Stall.
  4. Stall: PC, IF/ID and FetchCount all hold their values.
  5. Normal: IFID_Instruction<=InstrData, IFID_PCPlus4<=PC+4, IFID_Valid<=1, PC<=PC+4, FetchCount<=FetchCount+1.
- Latency: a word at address A appears on IFID_Instruction one clock edge after PC=A, provided the cycle is not stalled.
- Arithmetic: PC+4 is 32-bit modulo. 32'hFFFFFFFC wraps to 0, and IFID_PCPlus4 then reads 0. FetchCount wraps modulo 2^32.
- Reset mid-operation: reset state is taken on that edge from any state, discarding any pending Stall, Redirect or Halt.
- Redirect and Halt in the same cycle: Halt wins. PC is not updated.

Test Plan:
- Reset, then release: cycle 1 is START, so InstrAddress=0 and IFID_Valid=0. In the next 3 cycles InstrAddress reads 0, 4, 8. IFID_PCPlus4 follows 4, 8, 12, Valid=1, and FetchCount reaches 3.
- Stall asserted for 2 cycles while PC=16: InstrAddress stays 16, and IFID and FetchCount are unchanged. After release PC=20 and IFID_PCPlus4=20.
- Redirect with RedirectTarget=32'h00000043 while PC=8: next PC=0x40 and IFID_Valid=0 for one cycle. On the following edge IFID_PCPlus4=0x44.
- Redirect and Stall together with target 0x100: PC becomes 0x100 and IF/ID becomes a bubble.
- Halt at PC=0x20: Halted=1 next cycle. PC stays 0x20 and IFID_Valid stays 0 for 5 further cycles. Reset then returns PC to RESET_PC with Halted=0.
- Redirect to 0xFFFFFFFC, then one normal cycle: IFID_PCPlus4=0 and PC=0. Also assert Reset during an active Stall and confirm all outputs take reset values on that edge.
